config_debounced: RTL and testbench

- Parametrised successor to the DIP-switch mode selector.
- Synchronises and debounces an active-low switch bank of configurable width.
- Decodes the one-hot-low pattern to a video mode code through a parameter look-up table.
- Outputs the committed mode plus a one-cycle change strobe to the framebuffer/video timing logic.

---
 rtl/config_pkg.sv | 28 ++
 rtl/config_debounced_sw_decode.sv | 34 +++
 rtl/config_debounced.sv | 159 +++++++++++++++
 tb/tb_config_debounced.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared constants and types for the debounced video-mode selector.
//   MODE_*           : video mode codes (MODE_W_DEF bits)
//   DEFAULT_FB_MODE  : code used when the switch pattern is not one-hot-low
//   state_e          : qualifier FSM states
//   DEFAULT_MODE_LUT : packed LUT, slice i = mode selected by switch i
package config_pkg;

    localparam int unsigned MODE_W_DEF = 8;
    localparam int unsigned NUM_SW_DEF = 5;

    localparam logic [MODE_W_DEF-1:0] MODE_1080p      = 8'h01;
    localparam logic [MODE_W_DEF-1:0] MODE_1080i      = 8'h02;
    localparam logic [MODE_W_DEF-1:0] MODE_720p       = 8'h03;
    localparam logic [MODE_W_DEF-1:0] MODE_480p       = 8'h04;
    localparam logic [MODE_W_DEF-1:0] MODE_480i       = 8'h05;
    localparam logic [MODE_W_DEF-1:0] DEFAULT_FB_MODE = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Switch 0 lives in the least significant slice.
    localparam logic [NUM_SW_DEF*MODE_W_DEF-1:0] DEFAULT_MODE_LUT =
        {MODE_480i, MODE_480p, MODE_720p, MODE_1080i, MODE_1080p};

endpackage

// File: rtl/config_debounced_sw_decode.sv
// Combinational one-hot-low decoder for a switch pattern.
//   i_pattern : switch bank, active-low
//   o_valid_c : exactly one bit of i_pattern is low
//   o_index_c : position of that low bit, 0 when not valid
module sw_decode #(
    parameter  int unsigned NUM_SW = 5,
    localparam int unsigned IDX_W  = $clog2(NUM_SW)
) (
    input  logic [NUM_SW-1:0] i_pattern,
    output logic              o_valid_c,
    output logic [IDX_W-1:0]  o_index_c
);

    localparam int unsigned ZW = $clog2(NUM_SW + 1);

    logic [ZW-1:0] w_zeros;

    // Count low bits and remember the position of the last one seen.
    always_comb begin
        w_zeros   = '0;
        o_index_c = '0;
        for (int unsigned i = 0; i < NUM_SW; i++) begin
            if (!i_pattern[i]) begin
                w_zeros   = w_zeros + ZW'(1);
                o_index_c = IDX_W'(i);
            end
        end
        o_valid_c = (w_zeros == ZW'(1));
        if (!o_valid_c) begin
            o_index_c = '0;
        end
    end

endmodule

// File: rtl/config_debounced.sv
// Debounced DIP-switch video mode selector.
// Synchronises an active-low switch bank, requires it to be stable for
// DEBOUNCE_CYCLES+1 consecutive samples, then decodes it to a mode code.
// Optional build macro: CONFIG_HOLD_LAST_EN -- an invalid pattern keeps the
// previous mode code instead of switching to DEFAULT_MODE.
//   clock          : system clock
//   reset          : asynchronous active-high reset
//   config_in      : raw switch bank, active-low, asynchronous
//   config_data    : committed mode code
//   config_changed : one-cycle pulse when config_data takes a new value
//   config_valid   : committed pattern had exactly one switch low
//   sw_index       : index of the active switch, 0 when invalid
module config_debounced
    import config_pkg::*;
#(
    parameter int unsigned                NUM_SW          = 5,
    parameter int unsigned                MODE_W          = 8,
    parameter int unsigned                DEBOUNCE_CYCLES = 16,
    parameter logic [NUM_SW*MODE_W-1:0]   MODE_LUT        = DEFAULT_MODE_LUT,
    parameter logic [MODE_W-1:0]          DEFAULT_MODE    = DEFAULT_FB_MODE
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SW-1:0]         config_in,
    output logic [MODE_W-1:0]         config_data,
    output logic                      config_changed,
    output logic                      config_valid,
    output logic [$clog2(NUM_SW)-1:0] sw_index
);

    localparam int unsigned IDX_W = $clog2(NUM_SW);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NUM_SW-1:0] r_sync1, r_sync_q, r_cand, r_committed;
    logic [CNT_W-1:0]  r_cnt;
    state_e            r_state;
    logic [MODE_W-1:0] r_data;
    logic              r_changed, r_valid;
    logic [IDX_W-1:0]  r_idx;

    state_e            w_state_nxt;
    logic [NUM_SW-1:0] w_cand_nxt, w_committed_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [MODE_W-1:0] w_data_nxt, w_lut_mode, w_mode;
    logic              w_changed_nxt, w_valid_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_dec_valid;
    logic [IDX_W-1:0]  w_dec_index;

    sw_decode #(
        .NUM_SW (NUM_SW)
    ) u_decode (
        .i_pattern (r_cand),
        .o_valid_c (w_dec_valid),
        .o_index_c (w_dec_index)
    );

    // LUT slice for the decoded switch; constant slice bounds per iteration.
    always_comb begin
        w_lut_mode = DEFAULT_MODE;
        for (int unsigned i = 0; i < NUM_SW; i++) begin
            if (w_dec_index == IDX_W'(i)) begin
                w_lut_mode = MODE_LUT[i*MODE_W +: MODE_W];
            end
        end
    end

    // Mode code an invalid pattern commits to.
    always_comb begin
`ifdef CONFIG_HOLD_LAST_EN
        w_mode = w_dec_valid ? w_lut_mode : r_data;
`else
        w_mode = w_dec_valid ? w_lut_mode : DEFAULT_MODE;
`endif
    end

    // Two-flop synchroniser; idles high to match an all-released bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1  <= '1;
            r_sync_q <= '1;
        end else begin
            r_sync1  <= config_in;
            r_sync_q <= r_sync1;
        end
    end

    // Qualifier next-state and output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_cand_nxt      = r_cand;
        w_cnt_nxt       = r_cnt;
        w_committed_nxt = r_committed;
        w_data_nxt      = r_data;
        w_valid_nxt     = r_valid;
        w_idx_nxt       = r_idx;
        w_changed_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync_q != r_committed) begin
                    w_cand_nxt  = r_sync_q;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_sync_q != r_cand) begin
                    w_cand_nxt = r_sync_q;
                    w_cnt_nxt  = CNT_W'(1);
                end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                    w_state_nxt = COMMIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            COMMIT: begin
                // Re-committing the same code (bounce back, equal LUT codes) is silent.
                w_committed_nxt = r_cand;
                w_valid_nxt     = w_dec_valid;
                w_idx_nxt       = w_dec_index;
                w_data_nxt      = w_mode;
                w_changed_nxt   = (w_mode != r_data);
                w_state_nxt     = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cand      <= '1;
            r_cnt       <= '0;
            r_committed <= '1;
            r_data      <= DEFAULT_MODE;
            r_valid     <= 1'b0;
            r_idx       <= '0;
            r_changed   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_committed <= w_committed_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_idx       <= w_idx_nxt;
            r_changed   <= w_changed_nxt;
        end
    end

    assign config_data    = r_data;
    assign config_changed = r_changed;
    assign config_valid   = r_valid;
    assign sw_index       = r_idx;

endmodule

// File: tb/tb_config_debounced.sv
// Self-checking bench for config_debounced (NUM_SW=5, DEBOUNCE_CYCLES=4).
// Reference: the switch bank is sampled once per clock; a pattern commits one
// clock after it has been seen for DB+1 consecutive synchronised samples, all
// taken after the synchronised bank first disagreed with the committed pattern.
module tb_config_debounced;
    import config_pkg::*;

    localparam int NSW = 5;
    localparam int DB  = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] config_in;
    logic [7:0] config_data;
    logic       config_changed;
    logic       config_valid;
    logic [2:0] sw_index;

    always #5 clock = ~clock;

    config_debounced #(
        .NUM_SW          (NSW),
        .MODE_W          (8),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .config_in      (config_in),
        .config_data    (config_data),
        .config_changed (config_changed),
        .config_valid   (config_valid),
        .sw_index       (sw_index)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    logic [7:0] lut [NSW] = '{MODE_1080p, MODE_1080i, MODE_720p, MODE_480p, MODE_480i};
    logic [4:0] m_s1, m_s2, m_committed, commit_pat;
    logic [4:0] hist [$];
    int         sess_start, idle_from, commit_at;
    logic [7:0] m_data;
    logic       m_valid, m_changed;
    logic [2:0] m_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1; m_committed = '1; commit_pat = '1;
        hist.delete();
        sess_start = -1; idle_from = 0; commit_at = -1;
        m_data = DEFAULT_FB_MODE; m_valid = 1'b0; m_changed = 1'b0; m_idx = '0;
    endtask

    task automatic model_commit(input logic [4:0] pat);
        logic [7:0] code;
        code = m_data;
        m_valid = 1'b0;
        m_idx = '0;
        if ($countones(~pat) == 1) begin
            for (int i = 0; i < NSW; i++) begin
                if (!pat[i]) begin
                    m_valid = 1'b1;
                    m_idx   = 3'(i);
                    code    = lut[i];
                end
            end
        end else begin
`ifndef CONFIG_HOLD_LAST_EN
            code = DEFAULT_FB_MODE;
`endif
        end
        m_changed   = (code != m_data);
        m_data      = code;
        m_committed = pat;
    endtask

    task automatic model_edge(input logic [4:0] val);
        int         k;
        logic [4:0] s;
        bit         stable;
        k = hist.size();
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = val;
        hist.push_back(s);
        m_changed = 1'b0;
        if (commit_at == k) begin
            model_commit(commit_pat);
            idle_from  = k + 1;
            sess_start = -1;
            commit_at  = -1;
        end else if (commit_at < 0) begin
            if (sess_start < 0 && k >= idle_from && s != m_committed) sess_start = k;
            if (sess_start >= 0 && k - DB >= sess_start) begin
                stable = 1'b1;
                for (int j = k - DB; j <= k; j++) if (hist[j] != s) stable = 1'b0;
                if (stable) begin
                    commit_at  = k + 1;
                    commit_pat = s;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("config_data",    32'(config_data),    32'(m_data));
        chk("config_valid",   32'(config_valid),   32'(m_valid));
        chk("sw_index",       32'(sw_index),       32'(m_idx));
        chk("config_changed", 32'(config_changed), 32'(m_changed));
    endtask

    // Entered and left at a falling edge.
    task automatic step(input logic [4:0] val);
        config_in = val;
        @(posedge clock);
        model_edge(val);
        #1;
        check_all();
        @(negedge clock);
    endtask

    // Holds val for n clocks; reports the first step whose outputs moved and the pulse count.
    task automatic run_hold(input logic [4:0] val, input int n, output int first_change, output int pulses);
        logic [11:0] prev;
        first_change = -1;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            prev = {config_data, config_valid, sw_index};
            step(val);
            if ({config_data, config_valid, sw_index} != prev && first_change < 0) first_change = i;
            if (config_changed) pulses++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_data",    32'(config_data),    32'(DEFAULT_FB_MODE));
        chk("rst_valid",   32'(config_valid),   32'd0);
        chk("rst_changed", 32'(config_changed), 32'd0);
        chk("rst_index",   32'(sw_index),       32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int fc, np, hold;
        logic [4:0] v;
        reset = 1'b1;
        config_in = '1;
        model_reset();
        @(negedge clock);
        apply_reset();

        // Idle bank after reset: nothing commits.
        run_hold(5'b11111, 20, fc, np);
        chk("idle_pulses", 32'(np), 32'd0);
        chk("idle_data", 32'(config_data), 32'(DEFAULT_FB_MODE));

        // First selection: latency 7 clocks after the capturing edge.
        run_hold(5'b11110, 12, fc, np);
        chk("lat_1080p", 32'(fc), 32'd7);
        chk("pulse_1080p", 32'(np), 32'd1);
        chk("data_1080p", 32'(config_data), 32'(MODE_1080p));
        chk("valid_1080p", 32'(config_valid), 32'd1);

        // Short glitch and return to committed pattern: silent.
        run_hold(5'b11011, 3, fc, np);
        chk("glitch_chg", 32'(fc), 32'hffff_ffff);
        run_hold(5'b11110, 12, fc, np);
        chk("glitch_pulses", 32'(np), 32'd0);
        chk("glitch_data", 32'(config_data), 32'(MODE_1080p));

        // Bounce, then commit 7 clocks after the last bounce.
        run_hold(5'b10111, 1, fc, np);
        run_hold(5'b11111, 1, fc, np);
        run_hold(5'b10111, 12, fc, np);
        chk("lat_480p", 32'(fc), 32'd7);
        chk("pulse_480p", 32'(np), 32'd1);
        chk("data_480p", 32'(config_data), 32'(MODE_480p));
        chk("index_480p", 32'(sw_index), 32'd3);

        // Back to 1080p, then two switches low.
        run_hold(5'b11110, 12, fc, np);
        chk("data_back_1080p", 32'(config_data), 32'(MODE_1080p));
        run_hold(5'b11100, 12, fc, np);
        chk("lat_invalid", 32'(fc), 32'd7);
        chk("valid_invalid", 32'(config_valid), 32'd0);
        chk("index_invalid", 32'(sw_index), 32'd0);
`ifdef CONFIG_HOLD_LAST_EN
        chk("data_invalid", 32'(config_data), 32'(MODE_1080p));
        chk("pulse_invalid", 32'(np), 32'd0);
`else
        chk("data_invalid", 32'(config_data), 32'(DEFAULT_FB_MODE));
        chk("pulse_invalid", 32'(np), 32'd1);
`endif

        // Reset while qualifying 01111, then requalify from scratch.
        run_hold(5'b01111, 4, fc, np);
        chk("pre_reset_hold", 32'(fc), 32'hffff_ffff);
        apply_reset();
        run_hold(5'b01111, 12, fc, np);
        chk("lat_480i", 32'(fc), 32'd7);
        chk("data_480i", 32'(config_data), 32'(MODE_480i));
        chk("index_480i", 32'(sw_index), 32'd4);
        chk("pulse_480i", 32'(np), 32'd1);

        // Randomised patterns and hold times against the reference model.
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 2))
                0:       v = ~(5'b00001 << $urandom_range(0, NSW - 1));
                1:       v = 5'b11111;
                default: v = 5'($urandom);
            endcase
            hold = $urandom_range(1, 10);
            for (int h = 0; h < hold; h++) step(v);
            if ($urandom_range(0, 49) == 0) apply_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
